regfile: RTL and testbench

// - Dual-read, dual-write register file for the superscalar core's vector datapath.
// - Flat storage of 2^(REG_CNT+LOG_SUPERSCALAR_WIDTH) words, each REG_WIDTH bits.
// - Ports A/B are synchronous read ports; ports C/D are synchronous write ports.
// - Sits between decode/issue (addresses) and execute (operands and writeback).

---
 rtl/regfile.sv | 52 +++++
 tb/tb_regfile.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// Dual-read, dual-write register file: 1-cycle registered reads, read-first on collisions, port D wins write conflicts.
// No handshake; freeze stalls both writes and read outputs.
module regfile #(
   parameter int REG_CNT               = 4,
   parameter int LOG_SUPERSCALAR_WIDTH = 4,
   parameter int REG_WIDTH             = 288,
   localparam int AW                   = REG_CNT + LOG_SUPERSCALAR_WIDTH,
   localparam int DEPTH                = 1 << AW
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 freeze,
   input  logic                 port_c_we,
   input  logic                 port_d_we,
   input  logic [0:AW-1]        port_a_read_addr,
   input  logic [0:AW-1]        port_b_read_addr,
   input  logic [0:AW-1]        port_c_write_addr,
   input  logic [0:AW-1]        port_d_write_addr,
   input  logic [REG_WIDTH-1:0] port_c_in,
   input  logic [REG_WIDTH-1:0] port_d_in,
   output logic [REG_WIDTH-1:0] port_a_out,
   output logic [REG_WIDTH-1:0] port_b_out
);

   logic [REG_WIDTH-1:0] mem [DEPTH];

   logic c_wr;
   logic d_wr;

   assign c_wr = port_c_we && !freeze && !reset;
   assign d_wr = port_d_we && !freeze && !reset;

   // Storage has no reset; D is applied after C so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (c_wr)
         mem[port_c_write_addr] <= port_c_in;
      if (d_wr)
         mem[port_d_write_addr] <= port_d_in;
   end

   // Reads sample the array before this edge's writes land, giving read-first behaviour.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         port_a_out <= '0;
         port_b_out <= '0;
      end else if (!freeze) begin
         port_a_out <= mem[port_a_read_addr];
         port_b_out <= mem[port_b_read_addr];
      end
   end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: hand-computed expectations checked with immediate assertions.
module tb_regfile;
   localparam int AW = 8;
   localparam int W  = 288;

   logic           clk;
   logic           reset;
   logic           freeze;
   logic           port_c_we;
   logic           port_d_we;
   logic [0:AW-1]  port_a_read_addr;
   logic [0:AW-1]  port_b_read_addr;
   logic [0:AW-1]  port_c_write_addr;
   logic [0:AW-1]  port_d_write_addr;
   logic [W-1:0]   port_c_in;
   logic [W-1:0]   port_d_in;
   logic [W-1:0]   port_a_out;
   logic [W-1:0]   port_b_out;

   int checks   = 0;
   int failures = 0;

   regfile dut (
      .clk               (clk),
      .reset             (reset),
      .freeze            (freeze),
      .port_c_we         (port_c_we),
      .port_d_we         (port_d_we),
      .port_a_read_addr  (port_a_read_addr),
      .port_b_read_addr  (port_b_read_addr),
      .port_c_write_addr (port_c_write_addr),
      .port_d_write_addr (port_d_write_addr),
      .port_c_in         (port_c_in),
      .port_d_in         (port_d_in),
      .port_a_out        (port_a_out),
      .port_b_out        (port_b_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_ne(input string tag, input logic [W-1:0] obs, input logic [W-1:0] bad);
      checks++;
      assert (obs !== bad) else begin
         failures++;
         $error("FAIL %s observed=%0h required_not=%0h", tag, obs, bad);
      end
   endtask

   initial begin
      reset             = 1'b1;
      freeze            = 1'b0;
      port_c_we         = 1'b0;
      port_d_we         = 1'b0;
      port_a_read_addr  = '0;
      port_b_read_addr  = '0;
      port_c_write_addr = '0;
      port_d_write_addr = '0;
      port_c_in         = '0;
      port_d_in         = '0;

      // Reset state
      #2;
      check_eq("reset_a", port_a_out, '0);
      check_eq("reset_b", port_b_out, '0);
      tick();
      tick();
      reset = 1'b0;

      // Write then read
      port_c_we = 1'b1; port_c_write_addr = 8'd15; port_c_in = 'h2;
      tick();
      port_c_we = 1'b0;
      port_b_read_addr = 8'd15; port_a_read_addr = 8'd14;
      tick();
      check_eq("wr_rd_b15", port_b_out, 'h2);
      check_ne("wr_rd_a14", port_a_out, 'h2);

      // Swap ports
      port_a_read_addr = 8'd15; port_b_read_addr = 8'd12;
      tick();
      check_eq("swap_a15", port_a_out, 'h2);
      check_ne("swap_b12", port_b_out, 'h2);

      // Both write ports, distinct addresses
      port_c_we = 1'b1; port_c_write_addr = 8'd3;   port_c_in = 'hAA;
      port_d_we = 1'b1; port_d_write_addr = 8'd200; port_d_in = 'h55;
      tick();
      port_c_we = 1'b0; port_d_we = 1'b0;
      port_a_read_addr = 8'd3; port_b_read_addr = 8'd200;
      tick();
      check_eq("dual_a3",   port_a_out, 'hAA);
      check_eq("dual_b200", port_b_out, 'h55);
      port_a_read_addr = 8'd200; port_b_read_addr = 8'd3;
      tick();
      check_eq("dual_a200", port_a_out, 'h55);
      check_eq("dual_b3",   port_b_out, 'hAA);

      // Same-address dual write: D wins; both read ports on same entry
      port_c_we = 1'b1; port_c_write_addr = 8'd7; port_c_in = 'h111;
      port_d_we = 1'b1; port_d_write_addr = 8'd7; port_d_in = 'h222;
      tick();
      port_c_we = 1'b0; port_d_we = 1'b0;
      port_a_read_addr = 8'd7; port_b_read_addr = 8'd7;
      tick();
      check_eq("collide_a7", port_a_out, 'h222);
      check_eq("collide_b7", port_b_out, 'h222);

      // Freeze: outputs hold, write blocked
      port_a_read_addr = 8'd15; port_b_read_addr = 8'd3;
      tick();
      check_eq("prefrz_a", port_a_out, 'h2);
      check_eq("prefrz_b", port_b_out, 'hAA);
      freeze = 1'b1;
      port_c_we = 1'b1; port_c_write_addr = 8'd15; port_c_in = 'h9;
      port_a_read_addr = 8'd3; port_b_read_addr = 8'd200;
      tick();
      check_eq("frz1_a", port_a_out, 'h2);
      check_eq("frz1_b", port_b_out, 'hAA);
      tick();
      check_eq("frz2_a", port_a_out, 'h2);
      check_eq("frz2_b", port_b_out, 'hAA);
      freeze = 1'b0; port_c_we = 1'b0;
      port_a_read_addr = 8'd15; port_b_read_addr = 8'd200;
      tick();
      check_eq("postfrz_a15", port_a_out, 'h2);
      check_eq("postfrz_b200", port_b_out, 'h55);

      // Read-during-write returns old data, then new
      port_c_we = 1'b1; port_c_write_addr = 8'd15; port_c_in = 'h5;
      port_a_read_addr = 8'd15; port_b_read_addr = 8'd3;
      tick();
      check_eq("rdw_old", port_a_out, 'h2);
      port_c_we = 1'b0;
      tick();
      check_eq("rdw_new", port_a_out, 'h5);
      check_eq("rdw_b3",  port_b_out, 'hAA);

      // Async reset mid-cycle
      #2;
      reset = 1'b1;
      #1;
      check_eq("arst_a", port_a_out, '0);
      check_eq("arst_b", port_b_out, '0);
      tick();
      check_eq("arst_hold_a", port_a_out, '0);
      reset = 1'b0;
      port_a_read_addr = 8'd15; port_b_read_addr = 8'd200;
      tick();
      check_eq("post_rst_a15",  port_a_out, 'h5);
      check_eq("post_rst_b200", port_b_out, 'h55);
      port_a_read_addr = 8'd7; port_b_read_addr = 8'd3;
      tick();
      check_eq("post_rst_a7", port_a_out, 'h222);
      check_eq("post_rst_b3", port_b_out, 'hAA);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
